// File: rtl/flappy_pkg.sv
// rtl/flappy_pkg.sv - shared geometry constants, FSM state type and hit code helper
package flappy_pkg;

    localparam int NUM_COLS_DEF = 6;
    localparam int COORD_W      = 10;
    localparam int BIRD_SIZE    = 16;
    localparam int COL_W        = 40;
    localparam int GAP_H        = 120;
    localparam int GROUND_Y     = 440;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } scan_state_t;

    // A ground hit is reported as one past the last column index.
    function automatic int ground_code(input int num_cols);
        return num_cols;
    endfunction

endpackage

// File: rtl/collision_scanner_if.sv
// rtl/collision_scanner_if.sv - frame strobe, snapshot inputs and sticky collision outputs
interface collision_scanner_if #(
    parameter int NUM_COLS = flappy_pkg::NUM_COLS_DEF,
    parameter int COORD_W  = flappy_pkg::COORD_W
);
    localparam int HC_W = $clog2(NUM_COLS + 1);

    logic                         start;
    logic                         arm;
    logic                         clear;
    logic [COORD_W-1:0]           bird_x;
    logic [COORD_W-1:0]           bird_y;
    logic [NUM_COLS*COORD_W-1:0]  col_x;
    logic [NUM_COLS*COORD_W-1:0]  col_gap_y;
    logic [NUM_COLS-1:0]          col_valid;
    logic                         busy;
    logic                         done;
    logic                         collided;
    logic                         collision_pulse;
    logic [HC_W-1:0]              hit_col;

    modport master (
        output start, arm, clear, bird_x, bird_y, col_x, col_gap_y, col_valid,
        input  busy, done, collided, collision_pulse, hit_col
    );

    modport slave (
        input  start, arm, clear, bird_x, bird_y, col_x, col_gap_y, col_valid,
        output busy, done, collided, collision_pulse, hit_col
    );

endinterface

// File: rtl/collision_scanner_box_hit.sv
// rtl/collision_scanner_box_hit.sv - single-column bounding-box versus gap test
module box_hit #(
    parameter int COORD_W   = flappy_pkg::COORD_W,
    parameter int BIRD_SIZE = flappy_pkg::BIRD_SIZE,
    parameter int COL_W     = flappy_pkg::COL_W,
    parameter int GAP_H     = flappy_pkg::GAP_H
) (
    input  logic [COORD_W-1:0] bird_x_i,
    input  logic [COORD_W-1:0] bird_y_i,
    input  logic [COORD_W-1:0] col_x_i,
    input  logic [COORD_W-1:0] gap_y_i,
    input  logic               valid_i,
    output logic               hit_o
);
    localparam int W1 = COORD_W + 1;

    // One extra bit keeps right/bottom edges from wrapping near the screen edge.
    logic [W1-1:0] bird_l, bird_r, bird_t, bird_b;
    logic [W1-1:0] col_l, col_r, gap_t, gap_b;
    logic          x_overlap, y_outside;

    assign bird_l = {1'b0, bird_x_i};
    assign bird_r = bird_l + W1'(BIRD_SIZE - 1);
    assign bird_t = {1'b0, bird_y_i};
    assign bird_b = bird_t + W1'(BIRD_SIZE - 1);
    assign col_l  = {1'b0, col_x_i};
    assign col_r  = col_l + W1'(COL_W - 1);
    assign gap_t  = {1'b0, gap_y_i};
    assign gap_b  = gap_t + W1'(GAP_H - 1);

    assign x_overlap = (bird_l <= col_r) && (col_l <= bird_r);
    assign y_outside = (bird_t < gap_t) || (bird_b > gap_b);
    assign hit_o     = valid_i && x_overlap && y_outside;

endmodule

// File: rtl/collision_scanner.sv
// rtl/collision_scanner.sv - per-frame sequential column scan with sticky first-hit record
module collision_scanner
    import flappy_pkg::*;
#(
    parameter int NUM_COLS  = NUM_COLS_DEF,
    parameter int COORD_W   = flappy_pkg::COORD_W,
    parameter int BIRD_SIZE = flappy_pkg::BIRD_SIZE,
    parameter int COL_W     = flappy_pkg::COL_W,
    parameter int GAP_H     = flappy_pkg::GAP_H,
    parameter int GROUND_Y  = flappy_pkg::GROUND_Y
) (
    input logic                clk_i,
    input logic                rst_i,
    collision_scanner_if.slave bus
);
    localparam int HC_W        = $clog2(NUM_COLS + 1);
    localparam int IDX_W       = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam int W1          = COORD_W + 1;
    localparam int GROUND_CODE = ground_code(NUM_COLS);

    scan_state_t         state_q;
    logic [IDX_W-1:0]    idx_q;
    logic [COORD_W-1:0]  bird_x_q, bird_y_q;
    logic [COORD_W-1:0]  col_x_q   [NUM_COLS];
    logic [COORD_W-1:0]  col_gap_q [NUM_COLS];
    logic [NUM_COLS-1:0] col_valid_q;
    logic                arm_q;
    logic                found_q, ground_q;
    logic [IDX_W-1:0]    found_idx_q;
    logic                busy_q, done_q, collided_q, pulse_q;
    logic [HC_W-1:0]     hit_col_q;

    logic                col_hit_d, ground_d, scan_hit_d;
    logic [HC_W-1:0]     scan_code_d;

    box_hit #(
        .COORD_W  (COORD_W),
        .BIRD_SIZE(BIRD_SIZE),
        .COL_W    (COL_W),
        .GAP_H    (GAP_H)
    ) u_box_hit (
        .bird_x_i(bird_x_q),
        .bird_y_i(bird_y_q),
        .col_x_i (col_x_q[idx_q]),
        .gap_y_i (col_gap_q[idx_q]),
        .valid_i (col_valid_q[idx_q]),
        .hit_o   (col_hit_d)
    );

    assign ground_d    = ({1'b0, bird_y_q} + W1'(BIRD_SIZE - 1)) >= W1'(GROUND_Y);
    assign scan_hit_d  = found_q || ground_q;
    assign scan_code_d = found_q ? HC_W'(found_idx_q) : HC_W'(GROUND_CODE);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            bird_x_q    <= '0;
            bird_y_q    <= '0;
            col_valid_q <= '0;
            arm_q       <= 1'b0;
            found_q     <= 1'b0;
            ground_q    <= 1'b0;
            found_idx_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            collided_q  <= 1'b0;
            pulse_q     <= 1'b0;
            hit_col_q   <= '0;
            for (int i = 0; i < NUM_COLS; i++) begin
                col_x_q[i]   <= '0;
                col_gap_q[i] <= '0;
            end
        end else begin
            done_q  <= 1'b0;
            pulse_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        bird_x_q    <= bus.bird_x;
                        bird_y_q    <= bus.bird_y;
                        col_valid_q <= bus.col_valid;
                        arm_q       <= bus.arm;
                        for (int i = 0; i < NUM_COLS; i++) begin
                            col_x_q[i]   <= bus.col_x[i*COORD_W +: COORD_W];
                            col_gap_q[i] <= bus.col_gap_y[i*COORD_W +: COORD_W];
                        end
                        idx_q    <= '0;
                        found_q  <= 1'b0;
                        ground_q <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (idx_q == '0) ground_q <= ground_d;
                    // Only the first (lowest-index) hitting column is recorded.
                    if (col_hit_d && !found_q) begin
                        found_q     <= 1'b1;
                        found_idx_q <= idx_q;
                    end
                    if (idx_q == IDX_W'(NUM_COLS - 1)) state_q <= ST_DONE;
                    else                               idx_q   <= idx_q + 1'b1;
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= ST_IDLE;
                    if (scan_hit_d && arm_q && !collided_q && !bus.clear) begin
                        collided_q <= 1'b1;
                        hit_col_q  <= scan_code_d;
                        pulse_q    <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
            // Clear wins over a same-cycle set but leaves a running scan alone.
            if (bus.clear) begin
                collided_q <= 1'b0;
                hit_col_q  <= '0;
            end
        end
    end

    assign bus.busy            = busy_q;
    assign bus.done            = done_q;
    assign bus.collided        = collided_q;
    assign bus.collision_pulse = pulse_q;
    assign bus.hit_col         = hit_col_q;

endmodule
